// File: rtl/jk_ff_monitor.sv
// jk_ff_monitor: response checker for a J/K flip-flop with preset.
// Tracks an independent next-state model and flags Q/P mismatches.
module jk_ff_monitor #(
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic             J,
  input  logic             K,
  input  logic             PR,
  input  logic             Q,
  input  logic             P,
  output logic             ERR,
  output logic             ERR_STICKY,
  output logic [CNT_W-1:0] CHK_CNT,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] FIRST_IDX,
  output logic [1:0]       STATE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SYNC  = 2'b01,
    S_CHECK = 2'b10,
    S_FAULT = 2'b11
  } state_t;

  state_t           r_state;
  logic             r_exp_q;
  logic             r_err;
  logic             r_sticky;
  logic [CNT_W-1:0] r_chk;
  logic [CNT_W-1:0] r_ecnt;
  logic [CNT_W-1:0] r_first;

  logic w_nxt_obs;
  logic w_nxt_exp;
  logic w_mismatch;
  logic w_chk_sat;
  logic w_ecnt_sat;

  function automatic logic f_next(
    input logic s,
    input logic j,
    input logic k,
    input logic pr
  );
    logic n;
    n = s;
    if (pr) begin
      n = 1'b1;
    end else begin
      unique case ({j, k})
        2'b00: n = s;
        2'b01: n = 1'b0;
        2'b10: n = 1'b1;
        2'b11: n = ~s;
      endcase
    end
    return n;
  endfunction

  assign w_nxt_obs  = f_next(Q, J, K, PR);
  assign w_nxt_exp  = f_next(r_exp_q, J, K, PR);
  // Q and P faults in one cycle fold into a single mismatch
  assign w_mismatch = (Q != r_exp_q) | (P == Q);
  assign w_chk_sat  = &r_chk;
  assign w_ecnt_sat = &r_ecnt;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state  <= S_IDLE;
      r_exp_q  <= 1'b0;
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
      r_chk    <= '0;
      r_ecnt   <= '0;
      r_first  <= '0;
    end else begin
      r_err <= 1'b0;
      if (!EN) begin
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_state <= S_SYNC;
          end
          S_SYNC: begin
            r_exp_q <= w_nxt_obs;
            r_state <= S_CHECK;
          end
          S_CHECK: begin
            if (!w_chk_sat) r_chk <= r_chk + 1'b1;
            if (w_mismatch) begin
              r_err    <= 1'b1;
              r_sticky <= 1'b1;
              if (!w_ecnt_sat) r_ecnt <= r_ecnt + 1'b1;
              if (!r_sticky) r_first <= r_chk;
              // resync to the DUT so one fault is reported once
              r_exp_q <= w_nxt_obs;
              if (STOP_ON_ERR) r_state <= S_FAULT;
            end else begin
              r_exp_q <= w_nxt_exp;
            end
          end
          S_FAULT: begin
            r_state <= S_FAULT;
          end
        endcase
      end
    end
  end

  assign ERR        = r_err;
  assign ERR_STICKY = r_sticky;
  assign CHK_CNT    = r_chk;
  assign ERR_CNT    = r_ecnt;
  assign FIRST_IDX  = r_first;
  assign STATE      = r_state;

endmodule
